// File: rtl/leaf_tally.sv
`default_nettype none
// ============================================================================
// Module   : leaf_tally
// Purpose  : Per-leaf spike histogram for a dtree classifier. Every valid,
//            in-range (level, path) event increments bin level*FEATURES+path.
//            A dump request streams all BINS counts over a ready/valid port.
//            Each bin is snapshotted in a LOAD cycle and sent in a SEND cycle.
//            On the handshake, the sent amount is subtracted from the live
//            counter, so events that arrive during a dump are never lost.
// Ports    : clk         - single clock, rising edge
//            reset       - asynchronous, active-low
//            level/path  - leaf coordinates, sampled while in_valid=1
//            in_valid    - one classified spike per high cycle
//            dump_start  - request to stream all bins (honoured in IDLE)
//            dump_ready  - consumer ready
//            dump_valid/dump_data/dump_bin/dump_last - stream output
//            busy        - dump in progress
//            bad_leaf    - sticky: an out-of-range leaf was seen
// Revision : 1.0 - initial release
// ============================================================================
module leaf_tally #(
    parameter  int FEATURES  = 3,
    parameter  int CNT_WIDTH = 8,
    localparam int LW        = $clog2(FEATURES),
    localparam int BW        = $clog2(FEATURES * FEATURES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LW-1:0]        level,
    input  logic [LW-1:0]        path,
    input  logic                 in_valid,
    input  logic                 dump_start,
    input  logic                 dump_ready,
    output logic                 dump_valid,
    output logic [CNT_WIDTH-1:0] dump_data,
    output logic [BW-1:0]        dump_bin,
    output logic                 dump_last,
    output logic                 busy,
    output logic                 bad_leaf
);

    localparam int BINS = FEATURES * FEATURES;
    // level*FEATURES+path < 2^(2*LW+1), so this width can never truncate.
    localparam int IW   = 2 * LW + 1;

    localparam logic [LW:0]          FEAT_LIM = (LW + 1)'(FEATURES);
    localparam logic [BW-1:0]        LAST_BIN = BW'(BINS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] snap_q, snap_d;
    logic                 bad_q, bad_d;

    logic [CNT_WIDTH-1:0] bin_count [BINS];
    logic [IW-1:0]        leaf_idx;
    logic                 leaf_ok;
    logic                 ev_hit;
    logic                 drain;

    assign leaf_idx = IW'(level) * IW'(FEATURES) + IW'(path);
    assign leaf_ok  = ({1'b0, level} < FEAT_LIM) && ({1'b0, path} < FEAT_LIM);
    assign ev_hit   = in_valid && leaf_ok;
    // The handshake cycle is when the current bin gives back its snapshot.
    assign drain    = (state_q == ST_SEND) && dump_ready;

    // ------------------------------------------------------------------------
    // Per-bin counters
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < BINS; i++) begin : g_bin
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [CNT_WIDTH-1:0] base;
        logic                 hit;

        assign hit = ev_hit && (leaf_idx == IW'(i));

        // Subtract first, then saturate the increment on the result. A
        // saturated bin therefore gives back the clipped value only.
        always_comb begin
            base = cnt_q;
            if (drain && (ptr_q == BW'(i))) begin
                base = cnt_q - snap_q;
            end
            cnt_d = base;
            if (hit && (base != CNT_MAX)) begin
                cnt_d = base + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign bin_count[i] = cnt_q;
    end

    // ------------------------------------------------------------------------
    // Dump sequencer
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        snap_d  = snap_q;
        bad_d   = bad_q | (in_valid & ~leaf_ok);
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    ptr_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // An event landing this cycle goes to the bin, not the snapshot.
                snap_d  = bin_count[ptr_q];
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (dump_ready) begin
                    if (ptr_q == LAST_BIN) begin
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            snap_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            snap_q  <= snap_d;
            bad_q   <= bad_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state, held at zero outside SEND
    // ------------------------------------------------------------------------
    assign dump_valid = (state_q == ST_SEND);
    assign dump_data  = dump_valid ? snap_q : '0;
    assign dump_bin   = dump_valid ? ptr_q : '0;
    assign dump_last  = dump_valid && (ptr_q == LAST_BIN);
    assign busy       = (state_q != ST_IDLE);
    assign bad_leaf   = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_leaf_tally.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_tally
// Purpose  : Self-checking bench for leaf_tally (FEATURES=3, CNT_WIDTH=8).
//            Directed scenarios followed by a randomized run, all compared
//            each cycle against a histogram-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_tally;

    localparam int F    = 3;
    localparam int BINS = F * F;
    localparam int CMAX = 255;

    logic       clk;
    logic       reset;
    logic [1:0] level;
    logic [1:0] path;
    logic       in_valid;
    logic       dump_start;
    logic       dump_ready;
    logic       dump_valid;
    logic [7:0] dump_data;
    logic [3:0] dump_bin;
    logic       dump_last;
    logic       busy;
    logic       bad_leaf;

    leaf_tally #(
        .FEATURES  (F),
        .CNT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .level      (level),
        .path       (path),
        .in_valid   (in_valid),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_bin   (dump_bin),
        .dump_last  (dump_last),
        .busy       (busy),
        .bad_leaf   (bad_leaf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: histogram plus dump progress.
    // Phase values: 0 = idle, 1 = snapshot pending, 2 = offering a bin.
    int m_cnt [BINS];
    int m_phase;
    int m_ptr;
    int m_snap;
    bit m_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        foreach (m_cnt[b]) m_cnt[b] = 0;
        m_phase = 0;
        m_ptr   = 0;
        m_snap  = 0;
        m_bad   = 0;
    endtask

    task automatic model_step(input int lv, input int pt, input bit iv, input bit ds, input bit dr);
        bit ok;
        bit hs;
        int idx;
        int v;
        int old_at_ptr;
        ok  = iv && (lv < F) && (pt < F);
        idx = lv * F + pt;
        hs  = (m_phase == 2) && dr;
        old_at_ptr = m_cnt[m_ptr];
        if (iv && !ok) m_bad = 1;
        for (int b = 0; b < BINS; b++) begin
            v = m_cnt[b];
            if (hs && b == m_ptr) v = v - m_snap;
            if (ok && idx == b && v < CMAX) v = v + 1;
            m_cnt[b] = v;
        end
        case (m_phase)
            0: if (ds) begin m_ptr = 0; m_phase = 1; end
            1: begin m_snap = old_at_ptr; m_phase = 2; end
            default: if (dr) begin
                if (m_ptr == BINS - 1) m_phase = 0;
                else begin m_ptr = m_ptr + 1; m_phase = 1; end
            end
        endcase
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (m_phase == 2);
        check("dump_valid", dump_valid, ev);
        check("dump_data", dump_data, ev ? m_snap : 0);
        check("dump_bin", dump_bin, ev ? m_ptr : 0);
        check("dump_last", dump_last, ev && (m_ptr == BINS - 1));
        check("busy", busy, m_phase != 0);
        check("bad_leaf", bad_leaf, m_bad);
    endtask

    // Called just after a falling edge: check, drive, clock, update model.
    task automatic cycle(input int lv, input int pt, input bit iv, input bit ds, input bit dr);
        check_outputs();
        level      = lv[1:0];
        path       = pt[1:0];
        in_valid   = iv;
        dump_start = ds;
        dump_ready = dr;
        @(posedge clk);
        model_step(lv, pt, iv, ds, dr);
        @(negedge clk);
    endtask

    task automatic idle_outputs_zero(input string tag);
        check({tag, "_valid"}, dump_valid, 0);
        check({tag, "_last"}, dump_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_data"}, dump_data, 0);
        check({tag, "_bin"}, dump_bin, 0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        idle_outputs_zero("rst_async");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check("rst_bad_leaf", bad_leaf, 0);
        reset = 1'b1;
    endtask

    task automatic full_dump();
        cycle(0, 0, 0, 1, 1);
        repeat (2 * BINS + 2) cycle(0, 0, 0, 0, 1);
    endtask

    initial begin
        int  nb;
        int  stall;
        bit  found;
        reset      = 1'b0;
        level      = '0;
        path       = '0;
        in_valid   = 1'b0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Five events to bin 5, then a dump with ready held high.
        repeat (5) cycle(1, 2, 1, 0, 1);
        cycle(0, 0, 0, 1, 1);
        nb = 0;
        for (int k = 0; k < 2 * BINS + 4; k++) begin
            if (busy === 1'b1) nb++;
            cycle(0, 0, 0, 0, 1);
        end
        check("dump_cycles", nb, 2 * BINS);
        full_dump();

        // Saturation: 300 events into bin 0.
        repeat (300) cycle(0, 0, 1, 0, 1);
        full_dump();
        full_dump();

        // Stall on bin 4 with two events arriving during the stall.
        repeat (3) cycle(1, 1, 1, 0, 1);
        cycle(0, 0, 0, 1, 1);
        stall = 0;
        for (int k = 0; k < 3 * BINS + 8; k++) begin
            if (m_phase == 2 && m_ptr == 4 && stall < 4) begin
                cycle(1, 1, stall < 2, 0, 0);
                stall++;
            end else begin
                cycle(0, 0, 0, 0, 1);
            end
        end
        check("stall_cycles", stall, 4);
        full_dump();

        // Event on bin 2 in the same cycle as its handshake.
        cycle(0, 2, 1, 0, 1);
        cycle(0, 0, 0, 1, 1);
        for (int k = 0; k < 2 * BINS + 2; k++) begin
            cycle(0, 2, (m_phase == 2 && m_ptr == 2), 0, 1);
        end
        full_dump();

        // Out-of-range level.
        cycle(3, 0, 1, 0, 1);
        check("bad_after_oor", bad_leaf, 1);
        full_dump();
        check("bad_persists", bad_leaf, 1);

        // Reset in the middle of sending bin 3.
        repeat (4) cycle(1, 0, 1, 0, 1);
        cycle(2, 2, 1, 0, 1);
        cycle(0, 0, 0, 1, 1);
        found = 0;
        for (int k = 0; k < 3 * BINS && !found; k++) begin
            if (m_phase == 2 && m_ptr == 3) found = 1;
            else cycle(0, 0, 0, 0, 1);
        end
        check("reach_send3", found, 1);
        check("send3_valid", dump_valid, 1);
        do_reset();
        check("post_rst_busy", busy, 0);
        full_dump();
        repeat (2) cycle(2, 1, 1, 0, 1);
        full_dump();

        // Randomized traffic including out-of-range leaves and stalls.
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        // Drain whatever dump is in flight, then read everything out.
        for (int k = 0; k < 2 * BINS + 2; k++) cycle(0, 0, 0, 0, 1);
        full_dump();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
